// File: rtl/fsqrt_sched.sv
// rtl/fsqrt_sched.sv - round-robin scheduler sharing one pipelined fsqrt unit between N requesters
module fsqrt_sched #(
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [32*N-1:0] req_x,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [32*N-1:0] rsp_y,
    input  logic [N-1:0]    rsp_ready,
    output logic [31:0]     sq_x,
    input  logic [31:0]     sq_y,
    output logic            busy
);

    localparam int TW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]          out_q, out_d;
    logic [N-1:0]          elig, grant, rsp_hs;
    logic [TW-1:0]         ptr_q, ptr_d, gidx;
    logic                  gvld;
    logic [31:0]           sq_x_q, sq_x_d;
    logic [LAT:0]          pv_q, pv_d;
    logic [LAT:0][TW-1:0]  pt_q, pt_d;
    logic [N-1:0]          rv_q, rv_d;
    logic [32*N-1:0]       ry_q, ry_d;

    // Scan from ptr with wrap-around; first eligible requester wins.
    always_comb begin
        int idx;
        idx   = 0;
        elig  = req_valid & ~out_q;
        grant = '0;
        gidx  = '0;
        gvld  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!gvld && elig[idx]) begin
                gvld       = 1'b1;
                gidx       = idx[TW-1:0];
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        sq_x_d = sq_x_q;
        if (gvld) begin
            ptr_d  = (gidx == TW'(N - 1)) ? '0 : gidx + 1'b1;
            sq_x_d = req_x[int'(gidx)*32 +: 32];
        end
    end

    // Tag pipeline shadows the unit latency; stage LAT lines up with sq_y.
    always_comb begin
        pv_d    = '0;
        pt_d    = '0;
        pv_d[0] = gvld;
        pt_d[0] = gidx;
        for (int s = 1; s <= LAT; s++) begin
            pv_d[s] = pv_q[s-1];
            pt_d[s] = pt_q[s-1];
        end
    end

    always_comb begin
        rsp_hs = rv_q & rsp_ready;
        rv_d   = rv_q & ~rsp_hs;
        ry_d   = ry_q;
        for (int i = 0; i < N; i++) begin
            if (pv_q[LAT] && pt_q[LAT] == TW'(i)) begin
                rv_d[i]         = 1'b1;
                ry_d[i*32 +: 32] = sq_y;
            end
        end
        out_d = (out_q | grant) & ~rsp_hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            ptr_q  <= '0;
            sq_x_q <= '0;
            pv_q   <= '0;
            pt_q   <= '0;
            rv_q   <= '0;
            ry_q   <= '0;
        end else begin
            out_q  <= out_d;
            ptr_q  <= ptr_d;
            sq_x_q <= sq_x_d;
            pv_q   <= pv_d;
            pt_q   <= pt_d;
            rv_q   <= rv_d;
            ry_q   <= ry_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rv_q;
    assign rsp_y     = ry_q;
    assign sq_x      = sq_x_q;
    assign busy      = |out_q;

endmodule

// File: tb/tb_fsqrt_sched.sv
// tb/tb_fsqrt_sched.sv - directed self-checking bench for fsqrt_sched
module tb_fsqrt_sched;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_x;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [32*N-1:0] rsp_y;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     sq_x;
    logic [31:0]     sq_y;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    fsqrt_sched #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
        .sq_x(sq_x), .sq_y(sq_y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Unit model: LAT-deep delay; a few exact square roots, otherwise ~x.
    function automatic logic [31:0] unit_f(input logic [31:0] x);
        case (x)
            32'h40800000: return 32'h40000000;
            32'h00000000: return 32'h00000000;
            32'h41100000: return 32'h40400000;
            32'h3f800000: return 32'h3f800000;
            default:      return ~x;
        endcase
    endfunction

    logic [31:0] dl [LAT];
    always @(posedge clk) begin
        dl[0] <= sq_x;
        for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
    end
    assign sq_y = unit_f(dl[LAT-1]);

    typedef struct {
        int          lane;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ylane(input int l);
        return rsp_y[l*32 +: 32];
    endfunction

    function automatic logic [N-1:0] oh(input int l);
        return N'(1 << l);
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_y0", ylane(0), 32'h0);
        chk("reset_sq_x", sq_x, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        cyc();
    endtask

    vec_t        vt [4];
    int          first;
    int          g [3];
    int          ng;
    logic [31:0] xs [4];
    logic [31:0] ys [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_x = '0; rsp_ready = '1;
        vt[0] = '{0, 32'h40800000, 32'h40000000};
        vt[1] = '{0, 32'h00000000, 32'h00000000};
        vt[2] = '{1, 32'h41100000, 32'h40400000};
        vt[3] = '{3, 32'h3f800000, 32'h3f800000};
        do_reset();

        // Single ops: grant, latency of LAT+2, routing and value.
        for (int v = 0; v < 4; v++) begin
            req_x[vt[v].lane*32 +: 32] = vt[v].x;
            req_valid = oh(vt[v].lane);
            @(negedge clk);
            chk("single_grant", 32'(req_ready), 32'(oh(vt[v].lane)));
            cyc();
            req_valid = '0;
            first = -1;
            for (int t = 1; t <= 8; t++) begin
                @(negedge clk);
                if (rsp_valid != 0 && first < 0) begin
                    first = t;
                    chk("single_rsp_valid", 32'(rsp_valid), 32'(oh(vt[v].lane)));
                    chk("single_rsp_y", ylane(vt[v].lane), vt[v].y);
                end
                cyc();
            end
            chk("single_latency", 32'(first), 32'd5);
            chk("single_busy_after", 32'(busy), 32'h0);
        end

        // Full contention.
        do_reset();
        for (int i = 0; i < N; i++) req_x[i*32 +: 32] = 32'h11111111 * (i + 1);
        req_valid = '1;
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            chk("contend_grant", 32'(req_ready), (t < 4) ? 32'(oh(t)) : 32'h0);
            if (t >= 5) begin
                chk("contend_rsp_valid", 32'(rsp_valid), 32'(oh(t-5)));
                chk("contend_rsp_y", ylane(t-5), ~(32'h11111111 * (t - 4)));
            end else begin
                chk("contend_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            cyc();
            if (t == 3) req_valid = '0;
        end

        // Backpressure on requester 2.
        do_reset();
        req_x[2*32 +: 32] = 32'h40800000;
        req_valid = 4'b0100;
        rsp_ready = 4'b1011;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready), 32'h4);
        cyc();
        req_x[2*32 +: 32] = 32'h12345678;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            chk("bp_no_regrant", 32'(req_ready[2]), 32'h0);
            if (t >= 5) begin
                chk("bp_hold_valid", 32'(rsp_valid[2]), 32'h1);
                chk("bp_hold_y", ylane(2), 32'h40000000);
            end
            cyc();
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        chk("bp_pop_cycle_grant", 32'(req_ready), 32'h0);
        cyc();
        rsp_ready = 4'b1011;
        @(negedge clk);
        chk("bp_regrant", 32'(req_ready), 32'h4);
        chk("bp_valid_cleared", 32'(rsp_valid), 32'h0);
        chk("bp_y_held", ylane(2), 32'h40000000);
        cyc();
        req_valid = '0;

        // Fairness: ptr lands on 2 after granting 1.
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("fair_first", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 4'b1011;
        ng = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            chk("fair_onehot", 32'($onehot0(req_ready)), 32'h1);
            if (req_ready != 0 && ng < 3) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g[ng] = i;
                ng++;
            end
            cyc();
            if (ng == 3) req_valid = '0;
        end
        chk("fair_count", 32'(ng), 32'd3);
        chk("fair_order0", 32'(g[0]), 32'd3);
        chk("fair_order1", 32'(g[1]), 32'd0);
        chk("fair_order2", 32'(g[2]), 32'd1);

        // Reset while two ops are in flight.
        do_reset();
        req_x[0 +: 32]  = 32'h40800000;
        req_x[32 +: 32] = 32'h41100000;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("rmf_grant0", 32'(req_ready), 32'h1);
        cyc();
        @(negedge clk);
        chk("rmf_grant1", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int t = 3; t <= 10; t++) begin
            @(negedge clk);
            chk("rmf_no_rsp", 32'(rsp_valid), 32'h0);
            chk("rmf_busy", 32'(busy), 32'h0);
            cyc();
        end
        req_valid = 4'b0110;
        @(negedge clk);
        chk("rmf_ptr_zero", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;

        // Idle holes between requests on different lanes.
        do_reset();
        xs[0] = 32'h3f800000; ys[0] = 32'h3f800000;
        xs[1] = 32'h41100000; ys[1] = 32'h40400000;
        xs[2] = 32'h40800000; ys[2] = 32'h40000000;
        xs[3] = 32'hdeadbeef; ys[3] = 32'h21524110;
        for (int i = 0; i < N; i++) req_x[i*32 +: 32] = xs[i];
        for (int t = 0; t < 14; t++) begin
            req_valid = (t % 2 == 0 && t <= 6) ? oh(t / 2) : '0;
            @(negedge clk);
            chk("holes_grant", 32'(req_ready), 32'(req_valid));
            if (t >= 5 && t % 2 == 1 && t <= 11) begin
                chk("holes_rsp_valid", 32'(rsp_valid), 32'(oh((t - 5) / 2)));
                chk("holes_rsp_y", ylane((t - 5) / 2), ys[(t - 5) / 2]);
            end else begin
                chk("holes_no_rsp", 32'(rsp_valid), 32'h0);
            end
            cyc();
        end
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsqrt_sched.md
Name: fsqrt_sched

Overview:
Round-robin scheduler that shares one pipelined fsqrt unit between N requesters. It accepts one operand per cycle from the requester it grants and drives that operand into the unit. It tracks each requester's tag through the fixed unit latency. It routes each result back to the correct requester's response register, which has valid/ready backpressure. The block sits between the client ports (FPU issue lanes) and the single fsqrt instance.

Parameters:
N, 4, number of requesters (2..8)
LAT, 3, cycles from sq_x being driven to sq_y being valid (matches fsqrt)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N  requester i has an operand
req_x  in  32*N  operand of requester i, bits [32i+31:32i]
req_ready  out  N  one-hot grant; handshake when req_valid[i] & req_ready[i]
rsp_valid  out  N  result pending for requester i
rsp_y  out  32*N  result of requester i
rsp_ready  in  N  requester i consumes its result
sq_x  out  32  operand to shared fsqrt unit (registered)
sq_y  in  32  result from shared fsqrt unit
busy  out  1  any requester outstanding

Behaviour:
- Single clock domain (clk); rst is synchronous and active-high. Reset is sampled only at the clk edge.
- Reset values: rsp_valid=0, rsp_y=0, sq_x=0, all outstanding bits=0, pipeline valid bits=0, round-robin pointer ptr=0. With those values, busy=0 and req_ready=0.
- Per-requester state:
  - outstanding[i] is set on the req handshake.
  - It is cleared on the rsp handshake (rsp_valid[i] & rsp_ready[i]).
  - Each requester therefore has at most one operation in flight or pending.
- Eligibility: elig[i] = req_valid[i] & ~outstanding[i]. Because clearing is registered, a requester that pops its result in cycle c can be granted again no earlier than c+1.
- Arbitration is combinational:
  - Grant the first eligible index scanning ptr, ptr+1, … with wrap-around mod N.
  - req_ready is the one-hot grant; at most one bit is high per cycle.
  - req_ready never depends on req_ready of other cycles.
- Pointer update on a grant to index g: ptr <= (g+1) mod N. With no grant, ptr holds.
- Issue, when a grant occurs in cycle c:
  - sq_x <= req_x[g] at the end of c; it is valid during c+1.
  - Tag pipeline stage 0 gets valid=1, tag=g.
  - With no grant, stage 0 gets valid=0, and sq_x holds its previous value, which the unit's result then ignores.
- Tag pipeline: LAT+1 stages (stage 0 aligned to sq_x, stage LAT aligned to sq_y) of {valid, tag[clog2(N)-1:0]}. It shifts every cycle and never stalls.
- Capture: when stage LAT is valid, at the end of that cycle (c+1+LAT):
  - rsp_y[tag] <= sq_y.
  - rsp_valid[tag] <= 1.
- Capture is always possible because the slot is reserved by outstanding. No result can ever be dropped or collide.
- Latency: req handshake in cycle c → rsp_valid high in cycle c+LAT+2 (5 cycles at default).
- Throughput: aggregate 1 op/cycle; per requester 1 op per LAT+3 cycles when rsp_ready is tied high.
- Response hold: while rsp_valid[i] & ~rsp_ready[i], rsp_y[i] and rsp_valid[i] are stable. On the handshake, rsp_valid[i] <= 0 and rsp_y[i] holds.
- Ignored inputs: rsp_ready[i] while rsp_valid[i]=0 is ignored. req_x of ungranted requesters is ignored.
- Simultaneous events:
  - Capture for requester a and rsp handshake for a different requester b in the same cycle are independent.
  - Capture and handshake for the same requester cannot coincide.
- busy = OR of outstanding.
- Reset mid-operation: all in-flight tags and pending results are discarded. sq_y arriving after reset is ignored because the pipeline valid bits are 0. The first grant after reset starts from index 0.

Test Plan:
- Single op:
  - Stimulus: rst released, req_valid=0001, req_x[0]=0x40800000, rsp_ready=1; real fsqrt connected.
  - Required: req_ready=0001 in cycle c; rsp_valid[0]=1 in c+5 with rsp_y[0] within 1 ulp of 0x40000000. Separately, x=0x00000000 → rsp_y=0x00000000.
- Full contention:
  - Stimulus: req_valid=1111 held, rsp_ready=1111; unit stubbed as a LAT-deep delay returning ~x.
  - Required: grants 0,1,2,3 in cycles c..c+3; rsp_valid one-hot for bits 0,1,2,3 in c+5..c+8; each rsp_y[i]=~req_x[i].
- Backpressure:
  - Stimulus: requester 2 with rsp_ready[2]=0 for 10 cycles, req_valid[2] kept high.
  - Required: req_ready[2]=0 throughout; rsp_y[2] stable. After rsp_ready[2]=1 for one cycle, req_ready[2]=1 the following cycle.
- Fairness:
  - Stimulus: ptr=2 (after a grant to 1), req_valid=1011.
  - Required: grant order 3,0,1. Requester 1 re-asserting is not granted ahead of 3 or 0.
- Reset mid-flight:
  - Stimulus: grant requesters 0 and 1, assert rst for 1 cycle at c+2.
  - Required: rsp_valid stays 0000 through c+10, busy=0, ptr=0. With req_valid=0110, the next grant is to index 1.
- Idle holes:
  - Stimulus: requests in alternating cycles.
  - Required: no spurious rsp_valid; each result routed by tag with no cross-lane corruption.
